// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;

    // Occupancy of a stage: nothing, head only, head plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } stage_state_e;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_CTRL_W = 21;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step on inc, stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble,
// optional skid entry and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit HasSkid = (SKID != 0);

    stage_state_e      state_q, state_d;
    logic [WIDTH-1:0]  head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [WIDTH-1:0]  skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != EMPTY);

    if (HasSkid) begin : g_skid
        // Registered ready: only a full stage refuses input.
        assign in_ready = (state_q != FULL);
    end else begin : g_no_skid
        // Single entry: accept when empty or when the head leaves this cycle.
        assign in_ready = !out_valid | out_ready;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and entry updates; leaving to EMPTY always clears the head.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = BUSY;
                    head_data_d = in_data;
                    head_ctrl_d = in_ctrl;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    head_data_d = in_data;
                    head_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    // Only reachable with a skid entry; single-entry ready forbids it.
                    if (HasSkid) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end
                end else if (out_fire) begin
                    state_d     = EMPTY;
                    head_data_d = '0;
                    head_ctrl_d = '0;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d     = BUSY;
                    head_data_d = skid_data_q;
                    head_ctrl_d = skid_ctrl_q;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end
            end
            default: begin
                state_d     = EMPTY;
                head_data_d = '0;
                head_ctrl_d = '0;
                skid_data_d = '0;
                skid_ctrl_d = '0;
            end
        endcase

        // Flush wins over any simultaneous transfer in either direction.
        if (flush) begin
            state_d     = EMPTY;
            head_data_d = '0;
            head_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end
    end

    // State and entry registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign out_data = head_data_q;
    assign out_ctrl = out_valid ? head_ctrl_q : '0;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: a skid and a single-entry stage share stimulus; each is compared
// every cycle against a queue model of the stage's occupancy.
module tb_pipe_stage_reg;

    logic        CLK = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [20:0] in_ctrl;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] out_data1, out_data0;
    logic [20:0] out_ctrl1, out_ctrl0;
    logic [15:0] stall1, stall0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.WIDTH(32), .CTRL_W(21), .SKID(1), .CNT_W(16)) dut1 (
        .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ctrl(out_ctrl1), .stall_cnt(stall1)
    );

    pipe_stage_reg #(.WIDTH(32), .CTRL_W(21), .SKID(0), .CNT_W(16)) dut0 (
        .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_ctrl(out_ctrl0), .stall_cnt(stall0)
    );

    typedef struct packed {
        logic [20:0] ctrl;
        logic [31:0] data;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];
    int   stall_m1, stall_m0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from queue contents; capacity is 2 with skid, 1 without.
    task automatic compare_all();
        ent_t h1, h0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        check_eq("s1_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
        check_eq("s1_out_data", out_data1, h1.data);
        check_eq("s1_out_ctrl", 32'(out_ctrl1), 32'(h1.ctrl));
        check_eq("s1_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
        check_eq("s1_stall_cnt", 32'(stall1), stall_m1);
        check_eq("s0_out_valid", 32'(out_valid0), 32'(q0.size() > 0));
        check_eq("s0_out_data", out_data0, h0.data);
        check_eq("s0_out_ctrl", 32'(out_ctrl0), 32'(h0.ctrl));
        check_eq("s0_in_ready", 32'(in_ready0), 32'((q0.size() == 0) || out_ready));
        check_eq("s0_stall_cnt", 32'(stall0), stall_m0);
    endtask

    // Compare with current inputs applied, clock once, advance the models.
    task automatic cycle();
        bit   rdy1, rdy0, if1, of1, if0, of0, st1, st0;
        ent_t e;
        #1;
        compare_all();
        e    = '{ctrl: in_ctrl, data: in_data};
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || out_ready;
        if1  = in_valid && rdy1;
        if0  = in_valid && rdy0;
        of1  = (q1.size() > 0) && out_ready;
        of0  = (q0.size() > 0) && out_ready;
        st1  = (q1.size() > 0) && !out_ready;
        st0  = (q0.size() > 0) && !out_ready;
        @(posedge CLK);
        if (reset) begin
            stall_m1 = 0;
            stall_m0 = 0;
        end else begin
            if (st1 && stall_m1 < 65535) stall_m1++;
            if (st0 && stall_m0 < 65535) stall_m0++;
        end
        if (reset || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (of1) void'(q1.pop_front());
            if (if1) q1.push_back(e);
            if (of0) void'(q0.pop_front());
            if (if0) q0.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input logic [20:0] c, input bit r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 21'h0, 1'b1);
        stall_m1 = 0;
        stall_m0 = 0;
        @(posedge CLK);
        #1;
        cycle();                      // second reset cycle, outputs checked at reset values
        reset = 1'b0;

        // In-order stream at full rate.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'h0040_0000 + 32'(4 * k), 21'(k), 1'b1);
            cycle();
            check_eq("stream_data", out_data1, 32'h0040_0000 + 32'(4 * k));
        end
        drive(1'b0, 32'h0, 21'h0, 1'b1);
        cycle();
        cycle();

        // Skid absorb: A in head, B arrives as out_ready drops.
        drive(1'b1, 32'hAAAA_0001, 21'h11, 1'b1);
        cycle();
        drive(1'b1, 32'hBBBB_0002, 21'h22, 1'b0);
        cycle();
        check_eq("skid_in_ready_low", 32'(in_ready1), 32'h0);
        drive(1'b0, 32'h0, 21'h0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 21'h0, 1'b1);
        check_eq("skid_head_A", out_data1, 32'hAAAA_0001);
        cycle();
        check_eq("skid_head_B", out_data1, 32'hBBBB_0002);
        cycle();
        check_eq("skid_drained", 32'(out_valid1), 32'h0);

        // Flush collision in FULL.
        drive(1'b1, 32'h1111_0001, 21'h1, 1'b1);
        cycle();
        drive(1'b1, 32'h2222_0002, 21'h2, 1'b0);
        cycle();
        drive(1'b1, 32'hC0C0_C0C0, 21'h1C, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 21'h0, 1'b1);
        check_eq("flush_valid", 32'(out_valid1), 32'h0);
        check_eq("flush_data", out_data1, 32'h0);
        check_eq("flush_in_ready", 32'(in_ready1), 32'h1);
        cycle();
        cycle();

        // Drain to bubble.
        drive(1'b1, 32'hDEAD_BEEF, 21'h1F_FFFF, 1'b1);
        cycle();
        check_eq("drain_head", out_data1, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0, 21'h0, 1'b1);
        cycle();
        check_eq("drain_bubble", out_data1, 32'h0);

        // Single-entry: ready follows out_ready in the same cycle.
        drive(1'b1, 32'h5050_0001, 21'h5, 1'b1);
        cycle();
        drive(1'b1, 32'h5050_0002, 21'h6, 1'b0);
        #1;
        check_eq("s0_block_same_cycle", 32'(in_ready0), 32'h0);
        cycle();
        out_ready = 1'b1;
        #1;
        check_eq("s0_ready_same_cycle", 32'(in_ready0), 32'h1);
        cycle();
        check_eq("s0_refill", out_data0, 32'h5050_0002);
        drive(1'b0, 32'h0, 21'h0, 1'b1);
        cycle();

        // Long stall to saturation, then flush, then reset.
        drive(1'b1, 32'h7777_0007, 21'h7, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 21'h0, 1'b0);
        for (int i = 0; i < 70000; i++) cycle();
        check_eq("stall_sat", 32'(stall1), 32'h0000_FFFF);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_eq("stall_after_flush", 32'(stall1), 32'h0000_FFFF);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_eq("stall_after_reset", 32'(stall1), 32'h0);
        check_eq("s0_stall_after_reset", 32'(stall0), 32'h0);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 21'($urandom),
                  ($urandom_range(0, 3) != 0));
            flush = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        flush = 1'b0;
        reset = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, flush-to-bubble, and an optional skid entry. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block instantiated per stage boundary. Payload and control widths are configurable. A saturating counter records back-pressure cycles for performance analysis.

## Interface
- WIDTH, 32: payload bits (PC, instruction, operands, immediate, concatenated by the instantiator).
- CTRL_W, 21: control-signal bits. Forced to zero whenever the stage holds a bubble.
- SKID, 1: 1 means a two-entry stage with registered in_ready; 0 means a single-entry stage with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and the current input; insert a bubble.
- in_valid  in  1  upstream has a transfer.
- in_ready  out  1  stage accepts a transfer this cycle.
- in_data  in  WIDTH  payload.
- in_ctrl  in  CTRL_W  control bits.
- out_valid  out  1  stage presents a transfer.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload of the head entry.
- out_ctrl  out  CTRL_W  control bits of the head entry; 0 when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage consists of a head entry (drives the outputs) and, when SKID=1, a skid entry.
- States:
  - EMPTY: no entries held.
  - BUSY: head entry held.
  - FULL: head and skid entries held (SKID=1 only).
- in_ready:
  - SKID=1: in_ready = (state != FULL). It is decoded from registered state only.
  - SKID=0: in_ready = !out_valid | out_ready.
- EMPTY:
  - in_fire → BUSY, head ← input.
- BUSY:
  - in_fire & out_fire → BUSY, head ← input.
  - in_fire & !out_fire → FULL, skid ← input (SKID=1). When SKID=0 this case cannot occur.
  - !in_fire & out_fire → EMPTY.
  - Neither → hold.
- FULL:
  - out_fire → BUSY, head ← skid.
  - Otherwise hold.
  - in_valid is ignored, since in_ready=0.
- Head payload is in-order: the skid entry is always younger than the head entry.
- Bubble rule: on entering EMPTY by any path, out_data and out_ctrl are cleared to zero. A bubble is therefore an all-zero instruction with zero control.
- flush:
  - Next state is EMPTY; all entries are dropped; out_data and out_ctrl are zeroed.
  - Flush overrides a simultaneous in_fire: the input is lost, and upstream must treat the transfer as consumed.
  - Flush overrides a simultaneous out_fire; downstream still saw that transfer.
- reset: same effect as flush, and additionally clears stall_cnt to 0.
- stall_cnt:
  - Increments on every cycle with out_valid & !out_ready, and saturates at 2^CNT_W−1.
  - Unaffected by flush.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, state EMPTY. in_ready is 1 after reset (both modes).
- Latency: 1 cycle from in_fire (in EMPTY, or in BUSY with out_fire) to out_valid.
- Throughput: one transfer per cycle sustained while out_ready=1.
- SKID=1 back-pressure:
  - out_ready falling is seen at in_ready one cycle later.
  - The skid entry absorbs the one in-flight transfer.
  - After out_ready rises in FULL, in_ready rises the following cycle.
- flush or reset asserted at edge N: out_valid=0 in the cycle after edge N. in_ready=1 in that cycle.
- stall_cnt reflects the stall condition of cycle N after edge N+1.

## Structure
- Shared package pipe_pkg:
  - state typedef: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
  - default width constants: 32 for WIDTH, 21 for CTRL_W.
- Sub-module sat_counter (parameter CNT_W; inputs CLK, reset, inc; output count) implements stall_cnt.
- The FSM and the two entry registers stay in pipe_stage_reg.
- The SKID=0 variant is selected by generate; FULL is unreachable in that variant.

## Test plan
- Reset and stream:
  - Stimulus: assert reset 2 cycles; then in_valid=1 with in_data=0x00400000+4k, in_ctrl=k, for k=1..8; out_ready=1.
  - Required response: out_data follows 1 cycle later in order; out_ctrl=0 and out_valid=0 before the first transfer.
- Skid absorb (SKID=1):
  - Stimulus: in BUSY with head=A, drop out_ready with B on the input.
  - Required response: B is accepted into skid; in_ready=0 the next cycle.
  - Stimulus: raise out_ready.
  - Required response: A, then B, are delivered; no loss or duplication.
- Flush collision:
  - Stimulus: in FULL, assert flush together with in_valid carrying C.
  - Required response: next cycle out_valid=0, out_data=0, out_ctrl=0, in_ready=1; C never appears.
- Drain to bubble:
  - Stimulus: single transfer D=0xDEADBEEF consumed with in_valid=0 afterwards.
  - Required response: out_data returns to 0 the cycle after out_fire.
- Stall counter:
  - Stimulus: hold out_valid=1 with out_ready=0 for 70000 cycles (CNT_W=16).
  - Required response: stall_cnt saturates at 0xFFFF.
  - Stimulus: then flush.
  - Required response: stall_cnt stays at 0xFFFF.
  - Stimulus: then reset.
  - Required response: stall_cnt=0.
- SKID=0 mode:
  - Stimulus: out_ready=0 with head held, in_valid=1.
  - Required response: in_ready=0 in the same cycle.
  - Stimulus: raise out_ready with in_valid=1.
  - Required response: head is replaced in the same cycle (pass-through refill).
